// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war player-input path.
//
// Contents:
//   db_state_e    - debounce FSM state encoding. Bit 1 is the accepted button
//                   level, and bit 1 XOR bit 0 marks a pending candidate change.
//   DB_COUNT_SYN  - stable-sample count for a 5 ms window at 50 MHz.
//   DB_COUNT_SIM  - short stable-sample count for simulation.
//   CNT_W_SYN / CNT_W_SIM - matching counter widths.
package tow_pkg;

    typedef enum logic [1:0] {
        S_IDLE_LO = 2'b00,
        S_PEND_HI = 2'b01,
        S_HI      = 2'b11,
        S_PEND_LO = 2'b10
    } db_state_e;

    localparam int DB_COUNT_SYN = 250000;
    localparam int DB_COUNT_SIM = 4;
    localparam int CNT_W_SYN    = 18;
    localparam int CNT_W_SIM    = 3;

endpackage

// File: rtl/push_debounce_sync_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level.
// It can be reused for any async input, such as reset-button conditioning.
//
// Ports:
//   clk - sampling clock (rising edge)
//   rst - asynchronous active-low reset; both flops clear to 0
//   d   - asynchronous input level
//   q   - level synchronized to clk, delayed by two edges
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/push_debounce_sync.sv
// push_debounce_sync: conditions one raw push-button into a clean,
// clock-synchronous level for the one-pulse round-win detector.
// The raw input passes through a two-flop synchronizer. A debounce FSM then
// accepts a level change only after DB_COUNT consecutive stable samples.
//
// Parameters:
//   DB_COUNT - consecutive stable samples needed to accept a change
//              (1 <= DB_COUNT <= 2**CNT_W)
//   CNT_W    - width of the stable-sample counter
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   pb_raw    - raw bouncing button level (1 = pressed)
//   sypush    - debounced synchronized level (registered decode)
//   bouncing  - high while a candidate change is being qualified
//   dbg_state - current FSM state, for debug and checkers
//
// Valid/ready: none. This is a free-running level conditioner. sypush is
// meaningful on every cycle, and there is no back-pressure.
module push_debounce_sync
    import tow_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_SYN,
    parameter int CNT_W    = CNT_W_SYN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_raw,
    output logic       sypush,
    output logic       bouncing,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic             sync1;
    db_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // pb_raw reaches the FSM only through the synchronizer.
    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (pb_raw),
        .q   (sync1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE_LO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter defaults to 0. It advances only while a pending level is
    // still being seen, so it stops at CNT_LAST and never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            S_IDLE_LO: begin
                if (sync1) state_nxt = S_PEND_HI;
            end
            S_PEND_HI: begin
                if (!sync1)                state_nxt = S_IDLE_LO;
                else if (cnt == CNT_LAST)  state_nxt = S_HI;
                else                       cnt_nxt   = cnt + 1'b1;
            end
            S_HI: begin
                if (!sync1) state_nxt = S_PEND_LO;
            end
            S_PEND_LO: begin
                if (sync1)                 state_nxt = S_HI;
                else if (cnt == CNT_LAST)  state_nxt = S_IDLE_LO;
                else                       cnt_nxt   = cnt + 1'b1;
            end
            default: state_nxt = S_IDLE_LO;
        endcase
    end

    // Outputs decode only from the state register, so they cannot glitch.
    // The state encoding also gives the async reset immediate effect on them.
    always_comb begin
        sypush    = state[1];
        bouncing  = state[1] ^ state[0];
        dbg_state = state;
    end

endmodule

// File: tb/tb_push_debounce_sync.sv
// Testbench for push_debounce_sync with DB_COUNT=4 and CNT_W=3.
//
// The reference model counts consecutive synchronized samples that differ
// from the accepted level. After DB_COUNT+1 such samples, the accepted level
// flips. A downstream one-pulse detector (winrnd = rise of sypush) is
// modelled on both sides.
module tb_push_debounce_sync;
    import tow_pkg::*;

    localparam int DB = DB_COUNT_SIM;
    localparam int CW = CNT_W_SIM;
    localparam int W  = 5;   // {state[1:0], bouncing, sypush, winrnd}

    // ---------------- clock / reset ----------------
    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       pb_raw = 1'b0;
    logic       sypush;
    logic       bouncing;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    push_debounce_sync #(.DB_COUNT(DB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pb_raw    (pb_raw),
        .sypush    (sypush),
        .bouncing  (bouncing),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           edge_n   = 0;
    int           rises    = 0;
    int           rise_edge = -1;
    int           fall_edge = -1;
    logic         sy_d     = 1'b0;

    // reference model
    logic m_s0  = 1'b0;
    logic m_s1  = 1'b0;
    logic m_lvl = 1'b0;
    int   m_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    endtask

    function automatic logic [1:0] model_state(input logic lvl, input int run);
        if (!lvl) return (run == 0) ? 2'b00 : 2'b01;
        else      return (run == 0) ? 2'b11 : 2'b10;
    endfunction

    task automatic model_reset();
        m_s0  = 1'b0;
        m_s1  = 1'b0;
        m_lvl = 1'b0;
        m_run = 0;
        sy_d  = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Drive one raw sample, take one clock edge, predict, then compare.
    task automatic step(input logic b, input string tag);
        logic         lvl_prev;
        logic [W-1:0] got;
        logic         wr;
        pb_raw = b;
        @(posedge clk);
        edge_n++;
        lvl_prev = m_lvl;
        if (m_s1 != m_lvl) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_lvl = ~m_lvl;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s1 = m_s0;
        m_s0 = b;
        exp_q.push_back({model_state(m_lvl, m_run), (m_run != 0), m_lvl, (m_lvl & ~lvl_prev)});
        #1;
        wr  = sypush & ~sy_d;
        got = {dbg_state, bouncing, sypush, wr};
        check(tag, 32'(got), 32'(exp_q.pop_front()));
        if (wr) begin
            rises++;
            rise_edge = edge_n;
        end
        if (!sypush && sy_d) fall_edge = edge_n;
        sy_d = sypush;
    endtask

    task automatic hold(input logic b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    // ---------------- stimulus ----------------
    int k;
    int r0;

    initial begin
        // Reset state while rst is held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'({dbg_state, bouncing, sypush}), 32'(0));
        #1 rst = 1'b1;   // released between edges
        model_reset();
        edge_n = 0;

        // Clean press: first sampled at edge 5, so it rises after edge 5+2+DB.
        hold(1'b0, 4, "idle");
        rise_edge = -1;
        step(1'b1, "press");
        hold(1'b1, 14, "press_hold");
        check("press_latency", 32'(rise_edge), 32'(5 + 2 + DB));

        // Clean release: first 0 sampled at edge 20, so it falls after edge 26.
        fall_edge = -1;
        step(1'b0, "release");
        hold(1'b0, 9, "release_hold");
        check("release_latency", 32'(fall_edge), 32'(20 + 2 + DB));

        // Release with a one-cycle 1 glitch: qualification restarts.
        hold(1'b1, 12, "press2");
        k = edge_n + 1;
        fall_edge = -1;
        hold(1'b0, 3, "rel_glitch_a");
        step(1'b1, "rel_glitch");
        hold(1'b0, 12, "rel_glitch_b");
        check("glitch_release_latency", 32'(fall_edge), 32'(k + 4 + 2 + DB));

        // Bouncy press: 1,0,1,0 then held 1.
        r0 = rises;
        step(1'b1, "bounce");
        step(1'b0, "bounce");
        step(1'b1, "bounce");
        step(1'b0, "bounce");
        k = edge_n + 1;
        hold(1'b1, 12, "bounce_hold");
        check("bounce_latency", 32'(rise_edge), 32'(k + 2 + DB));
        check("bounce_one_rise", 32'(rises - r0), 32'(1));
        hold(1'b0, 12, "bounce_release");

        // Short glitch: two cycles high in IDLE_LO are rejected.
        r0 = rises;
        hold(1'b1, 2, "short_glitch");
        hold(1'b0, 10, "short_glitch_tail");
        check("short_glitch_no_rise", 32'(rises - r0), 32'(0));
        check("short_glitch_idle", 32'(dbg_state), 32'(S_IDLE_LO));

        // Async reset during PEND_HI (cnt=2), with the button still held.
        hold(1'b1, 5, "pend_pre_rst");
        check("pend_before_rst", 32'(dbg_state), 32'(S_PEND_HI));
        #2 rst = 1'b0;
        #1;
        check("async_rst_outs", 32'({dbg_state, bouncing, sypush}), 32'(0));
        model_reset();
        #2 rst = 1'b1;
        edge_n = 0;
        rise_edge = -1;
        hold(1'b1, 10, "post_rst_hold");
        check("post_rst_latency", 32'(rise_edge), 32'(1 + 2 + DB));
        hold(1'b0, 12, "post_rst_release");

        // Downstream one-pulse: three bouncy presses give three winrnd pulses.
        r0 = rises;
        for (int p = 0; p < 3; p++) begin
            step(1'b1, "opp_press");
            step(1'b0, "opp_press");
            step(1'b1, "opp_press");
            step(1'b1, "opp_press");
            step(1'b0, "opp_press");
            hold(1'b1, 10, "opp_hold");
            step(1'b0, "opp_rel");
            step(1'b1, "opp_rel");
            hold(1'b0, 10, "opp_rel_hold");
        end
        check("opp_three_pulses", 32'(rises - r0), 32'(3));

        // Random run lengths around the debounce window.
        for (int r = 0; r < 60; r++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 2 * DB + 3), "random");
        end

        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
